// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

    // Targets are word addresses; low two bits never reach the PC.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_register.sv
// IF/ID pipeline register: write-enable, flush-to-bubble, async active-low reset.
module ifid_register
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we_i,
    input  logic  flush_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t ifid_q;

    // Flush outranks write so a redirect always leaves a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= IFID_BUBBLE;
        end else if (flush_i) begin
            ifid_q <= IFID_BUBBLE;
        end else if (we_i) begin
            ifid_q <= d_i;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, ready-handshake memory reads, skid buffer and drain
// of abandoned reads, feeding the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write_i,
    input  logic            ifid_write_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] ifid_instruction_o,
    output logic [XLEN-1:0] ifid_pc_plus4_o,
    output logic            ifid_valid_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    ifid_t           skid_q, skid_d;

    ifid_t           ifid_d, ifid_q;
    logic            ifid_we, ifid_flush;
    logic            advance, redirect, rdy;
    logic [XLEN-1:0] target, pc_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            skid_q  <= IFID_BUBBLE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        advance    = pc_write_i & ifid_write_i;
        redirect   = jump_i | branch_taken_i;
        target     = jump_i ? word_align(jump_target_i) : word_align(branch_target_i);
        rdy        = imem_ready_i & req_q;
        pc_inc     = pc_q + XLEN'(4);

        state_d    = state_q;
        pc_d       = pc_q;
        skid_d     = skid_q;
        ifid_d     = IFID_BUBBLE;
        ifid_we    = 1'b0;
        ifid_flush = ifid_write_i;

        case (state_q)
            ST_FETCH: begin
                if (rdy) begin
                    if (advance) begin
                        ifid_d     = '{instr: imem_rdata_i, pc_plus4: pc_inc, valid: 1'b1};
                        ifid_we    = 1'b1;
                        ifid_flush = 1'b0;
                        pc_d       = pc_inc;
                    end else begin
                        skid_d  = '{instr: imem_rdata_i, pc_plus4: pc_inc, valid: 1'b1};
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (advance) begin
                    ifid_d     = skid_q;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b0;
                    pc_d       = pc_inc;
                    skid_d     = IFID_BUBBLE;
                    state_d    = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (rdy) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // A read still in flight must complete before the target can be requested.
        if (redirect) begin
            pc_d       = target;
            skid_d     = IFID_BUBBLE;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            state_d    = (req_q && !rdy) ? ST_DRAIN : ST_FETCH;
        end

        req_d  = (state_d != ST_HOLD);
        addr_d = (state_d == ST_DRAIN) ? addr_q : pc_d;
    end

    ifid_register u_ifid_register (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ifid_we),
        .flush_i (ifid_flush),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign imem_req_o         = req_q;
    assign imem_addr_o        = addr_q;
    assign pc_o               = pc_q;
    assign ifid_instruction_o = ifid_q.instr;
    assign ifid_pc_plus4_o    = ifid_q.pc_plus4;
    assign ifid_valid_o       = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stalls,
// redirects and memory latency against a transaction-level reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write_i = 1'b0, ifid_write_i = 1'b0;
    logic        branch_taken_i = 1'b0, jump_i = 1'b0;
    logic [31:0] branch_target_i = '0, jump_target_i = '0;
    logic        imem_req_o, imem_ready_i = 1'b0;
    logic [31:0] imem_addr_o, imem_rdata_i = '0;
    logic [31:0] pc_o, ifid_instruction_o, ifid_pc_plus4_o;
    logic        ifid_valid_o;

    fetch_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pc_write_i         (pc_write_i),
        .ifid_write_i       (ifid_write_i),
        .branch_taken_i     (branch_taken_i),
        .branch_target_i    (branch_target_i),
        .jump_i             (jump_i),
        .jump_target_i      (jump_target_i),
        .imem_req_o         (imem_req_o),
        .imem_addr_o        (imem_addr_o),
        .imem_ready_i       (imem_ready_i),
        .imem_rdata_i       (imem_rdata_i),
        .pc_o               (pc_o),
        .ifid_instruction_o (ifid_instruction_o),
        .ifid_pc_plus4_o    (ifid_pc_plus4_o),
        .ifid_valid_o       (ifid_valid_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: expected outputs after the next rising edge.
    logic [31:0] m_pc, m_addr, m_instr, m_pc4;
    logic        m_valid, m_req, m_drop;
    logic [63:0] m_buf[$];

    // Memory model: fixed or random wait states, data = address ^ key.
    int          mem_wait_cfg = 0;
    int          cur_wait = 0;
    int          wcnt = 0;
    logic [31:0] data_key = '0;

    int          cyc = 0;
    int          seen_cyc[$];
    logic [31:0] seen_instr[$];
    logic [31:0] seen_pc4[$];

    function automatic int next_wait();
        return (mem_wait_cfg >= 0) ? mem_wait_cfg : int'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] seen_at(input int i);
        return (i < seen_instr.size()) ? seen_instr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pc4_at(input int i);
        return (i < seen_pc4.size()) ? seen_pc4[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic model_bubble();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {pc_write_i, ifid_write_i, branch_taken_i, jump_i, imem_ready_i} = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_drop = 1'b0;
        model_bubble();
        m_buf.delete();
        wcnt = 0;
        cur_wait = next_wait();
        seen_cyc.delete(); seen_instr.delete(); seen_pc4.delete();
        cyc = 0;
        check("rst_pc", pc_o, 32'h0);
        check("rst_req", 32'(imem_req_o), 32'h0);
        check("rst_valid", 32'(ifid_valid_o), 32'h0);
    endtask

    // Drive one cycle of inputs (called just after a falling edge), update the model,
    // then compare at the next falling edge.
    task automatic step(input logic pcw, input logic ifw,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt);
        logic        rdy, adv, redir;
        logic [31:0] tgt, rdata;
        rdy = 1'b0;
        if (!m_req) begin
            wcnt = 0;
        end else if (wcnt >= cur_wait) begin
            rdy = 1'b1;
            wcnt = 0;
            cur_wait = next_wait();
        end else begin
            wcnt++;
        end
        rdata = rdy ? (m_addr ^ data_key) : $urandom();

        pc_write_i = pcw; ifid_write_i = ifw;
        branch_taken_i = br; branch_target_i = bt;
        jump_i = jp; jump_target_i = jt;
        imem_ready_i = rdy; imem_rdata_i = rdata;

        adv   = pcw & ifw;
        redir = jp | br;
        tgt   = (jp ? jt : bt) & 32'hFFFF_FFFC;
        if (redir) begin
            m_drop = m_req && !rdy;
            m_buf.delete();
            m_pc = tgt;
            model_bubble();
        end else if (m_drop) begin
            if (rdy) m_drop = 1'b0;
            if (ifw) model_bubble();
        end else if (m_buf.size() != 0) begin
            if (adv) begin
                {m_instr, m_pc4} = m_buf.pop_front();
                m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end else if (ifw) begin
                model_bubble();
            end
        end else if (rdy) begin
            if (adv) begin
                m_instr = rdata;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end else begin
                m_buf.push_back({rdata, m_pc + 32'd4});
                if (ifw) model_bubble();
            end
        end else if (ifw) begin
            model_bubble();
        end
        m_req = (m_buf.size() == 0);
        if (!m_drop) m_addr = m_pc;

        @(negedge clk);
        check("pc", pc_o, m_pc);
        check("req", 32'(imem_req_o), 32'(m_req));
        if (m_req) check("addr", imem_addr_o, m_addr);
        check("instr", ifid_instruction_o, m_instr);
        check("pc4", ifid_pc_plus4_o, m_pc4);
        check("valid", 32'(ifid_valid_o), 32'(m_valid));
        if (ifid_valid_o) begin
            seen_cyc.push_back(cyc);
            seen_instr.push_back(ifid_instruction_o);
            seen_pc4.push_back(ifid_pc_plus4_o);
        end
        cyc++;
    endtask

    task automatic go(input int n);
        repeat (n) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        // Zero-wait memory, address-as-data streaming.
        mem_wait_cfg = 0; data_key = '0;
        do_reset();
        go(4);
        check("a_count", 32'(seen_instr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("a_instr", seen_at(i), 32'(4 * i));
            check("a_pc4", pc4_at(i), 32'(4 * i + 4));
        end

        // Stall three cycles while fetching 0x10.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("b_req_hold", 32'(imem_req_o), 32'h0);
        check("b_pc_hold", pc_o, 32'h10);
        go(1);
        check("b_instr", ifid_instruction_o, 32'h10);
        check("b_next_addr", imem_addr_o, 32'h14);
        go(1);
        check("b_no_refetch", ifid_instruction_o, 32'h14);

        // Branch to 0x40 during a 2-wait fetch of 0x8.
        mem_wait_cfg = 2;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8);
        go(1);
        step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        check("c_drain_addr", imem_addr_o, 32'h8);
        check("c_drain_pc", pc_o, 32'h40);
        go(1);
        check("c_target_addr", imem_addr_o, 32'h40);
        check("c_bubble", 32'(ifid_valid_o), 32'h0);

        // Jump and branch together: jump wins.
        mem_wait_cfg = 0;
        do_reset();
        go(3);
        step(1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h103);
        check("d_pc", pc_o, 32'h100);
        check("d_bubble", 32'(ifid_valid_o), 32'h0);
        go(1);
        check("d_first", ifid_instruction_o, 32'h100);

        // Three wait states: valid instructions four cycles apart.
        mem_wait_cfg = 3;
        do_reset();
        go(20);
        check("e_count_ok", 32'(seen_cyc.size() >= 3), 32'h1);
        if (seen_cyc.size() >= 3) begin
            check("e_gap0", 32'(seen_cyc[1] - seen_cyc[0]), 32'd4);
            check("e_gap1", 32'(seen_cyc[2] - seen_cyc[1]), 32'd4);
        end

        // PC wrap from the top word.
        mem_wait_cfg = 0;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        go(1);
        check("f_instr", ifid_instruction_o, 32'hFFFF_FFFC);
        check("f_pc4", ifid_pc_plus4_o, 32'h0);
        check("f_pc", pc_o, 32'h0);

        // Reset asserted mid-wait returns outputs asynchronously.
        mem_wait_cfg = 3;
        do_reset();
        go(6);
        #2 rst_n = 1'b0;
        #1;
        check("g_pc", pc_o, 32'h0);
        check("g_req", 32'(imem_req_o), 32'h0);
        check("g_addr", imem_addr_o, 32'h0);
        check("g_instr", ifid_instruction_o, 32'h0);
        check("g_pc4", ifid_pc_plus4_o, 32'h0);
        check("g_valid", 32'(ifid_valid_o), 32'h0);

        // Randomized stalls, redirects and latency.
        mem_wait_cfg = -1; data_key = $urandom();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        r_br, r_jp;
            r_br = ($urandom_range(0, 15) == 0);
            r_jp = ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 6) != 0, $urandom_range(0, 6) != 0,
                 r_br, $urandom(), r_jp, $urandom());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC, issues instruction-memory reads through a ready-handshake, and loads the IF/ID pipeline register consumed by the decode stage and the data-hazard unit. It obeys the hazard unit's PC-write and IF/ID-write stall enables and the decode stage's branch/jump redirects. A skid buffer and a drain state let multi-cycle memory coexist with stalls and flushes without losing or duplicating instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID for bubbles and flushes
- Clk  in  1  pipeline clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- PCWrite  in  1  hazard-unit PC enable; 0 = stall
- IFIDWrite  in  1  hazard-unit IF/ID enable; 0 = hold IF/ID
- BranchTaken  in  1  decode resolved a taken branch this cycle
- BranchTarget  in  32  branch target
- Jump  in  1  decode resolved J/JAL/JR this cycle
- JumpTarget  in  32  jump target (JR register value already muxed in)
- IMemReq  out  1  read request
- IMemAddr  out  32  read address, word aligned
- IMemReady  in  1  read data valid this cycle; completes the request
- IMemRData  in  32  instruction word
- PC  out  32  current fetch PC
- IFID_Instruction  out  32  decode-stage instruction
- IFID_PCPlus4  out  32  PC+4 of that instruction
- IFID_Valid  out  1  1 = real instruction, 0 = bubble

## Operation
- States: FETCH, HOLD, DRAIN.
- Reset: PC=RESET_PC, state FETCH, IFID_Instruction=NOP_INSTR, IFID_PCPlus4=0, IFID_Valid=0, skid buffer empty; IMemReq=1 from first cycle after reset release.
- advance = PCWrite & IFIDWrite. redirect = Jump | BranchTaken; Jump target wins if both.
- FETCH: IMemReq=1, IMemAddr=PC, held stable until IMemReady.
  - Ready & advance: IF/ID <= {IMemRData, PC+4, Valid=1}; PC <= PC+4.
  - Ready & !advance: data to skid buffer with PC+4; -> HOLD. IF/ID held if IFIDWrite=0, else loaded with bubble.
  - !Ready: IF/ID loads bubble if IFIDWrite=1, else holds.
- HOLD: IMemReq=0. On advance: IF/ID <= buffer, PC <= PC+4, -> FETCH. Otherwise as above for IF/ID.
- Redirect (any state, highest priority): PC <= target; IF/ID <= bubble regardless of IFIDWrite; skid buffer discarded.
  - FETCH & !Ready -> DRAIN (outstanding read must complete). FETCH & Ready -> FETCH, data dropped. HOLD -> FETCH.
- DRAIN: IMemReq=1 with old address (latched), returned data discarded; on Ready -> FETCH. Redirect in DRAIN updates PC, stays DRAIN.
- PC arithmetic 32-bit, wraps 32'hFFFF_FFFC -> 0; bits[1:0] of targets forced to 0.

## Timing
- Zero-wait memory (IMemReady same cycle as request): one instruction per cycle, IF/ID updates on the edge ending the request cycle.
- N-wait memory: N bubbles into IF/ID per instruction when unstalled.
- Redirect penalty: one flushed slot, next fetch from target the following cycle (FETCH) or after drain completes.
- Stall release from HOLD: buffered instruction reaches IF/ID on the first edge with advance=1, no memory latency.
- Reset mid-request: request abandoned immediately; memory must tolerate IMemReq dropping.

## Structure
- Shared pipeline package: state enum (FETCH/HOLD/DRAIN), NOP_INSTR, RESET_PC defaults, IF/ID bundle widths.
- One sub-module: ifid_register (write-enable, flush-to-bubble, async active-low reset), reusable for later stage registers.

## Test plan
- Reset release, zero-wait memory returning addr-as-data: IF/ID shows 0,4,8 with PCPlus4 4,8,12, Valid=1 each cycle.
- IFIDWrite=PCWrite=0 for 3 cycles while fetching 0x10: IF/ID holds, state HOLD, IMemReq=0; on release IF/ID=instr@0x10, next fetch 0x14, no refetch.
- BranchTaken with target 0x40 during 2-wait fetch of 0x8: DRAIN until ready, data discarded, IF/ID bubble, next request addr 0x40.
- Jump and BranchTaken same cycle (0x100 vs 0x200): PC=0x100, one bubble.
- 3-wait memory, no stalls: exactly 3 bubbles (Valid=0) between consecutive valid instructions.
- PC at 32'hFFFF_FFFC fetches, next PC=0; Reset asserted mid-wait: all outputs return to reset values asynchronously.
